// File: rtl/irq_pkg.sv
// irq_pkg: shared sizes, FSM state encoding and helpers for the interrupt
// dispatch front end.
//   NUM_REQ  : number of request lines (fixed at 4)
//   ID_W     : width of a source id
//   state_t  : dispatcher FSM states; 2'b11 is unused and recovers to IDLE
//   id_onehot: decode a source id into a one-hot source vector
package irq_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational 4-to-2 priority encoder with enable.
// Bit 3 has the highest priority.
//   eligible : candidate sources (pending and not masked)
//   en       : encoder enable; when low, nothing is reported
//   id       : index of the highest-priority candidate (0 when none)
//   any      : at least one candidate present while enabled
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               en,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  // Select the highest set bit of eligible, gated by en.
  always_comb begin
    id  = 2'd0;
    any = 1'b0;
    if (en) begin
      any = |eligible;
      casez (eligible)
        4'b1???: id = 2'd3;
        4'b01??: id = 2'd2;
        4'b001?: id = 2'd1;
        default: id = 2'd0;
      endcase
    end else begin
      id  = 2'd0;
      any = 1'b0;
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// irq_dispatch: captures four level request lines as rising-edge events,
// keeps them pending, and offers the highest-priority unmasked one to a
// consumer through a valid/ack handshake followed by an eoi phase.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : global dispatch enable
//   req        : request lines (rising edge = new event)
//   mask       : per-source dispatch block (1 = blocked)
//   irq_valid  : request offered to consumer (REQ state)
//   irq_id     : id of offered / in-service source
//   irq_ack    : consumer accepts the offered id
//   eoi        : consumer finished servicing the current id
//   pending    : pending event register
//   busy       : high in REQ or SERVICE
module irq_dispatch
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic [NUM_REQ-1:0] pending,
  output logic               busy
);

  logic [NUM_REQ-1:0] req_q_r;
  state_t             state_r;
  logic [NUM_REQ-1:0] rise_s;
  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] clr_s;
  logic [ID_W-1:0]    sel_s;
  logic               any_s;

  assign rise_s     = req & ~req_q_r;
  assign eligible_s = pending & ~mask;

  irq_prio_enc u_prio_enc (
    .eligible (eligible_s),
    .en       (en),
    .id       (sel_s),
    .any      (any_s)
  );

  // Pending bit to clear when the consumer accepts the offered id.
  always_comb begin
    clr_s = 4'b0000;
    if ((state_r == REQ) && irq_ack) begin
      clr_s = id_onehot(irq_id);
    end else begin
      clr_s = 4'b0000;
    end
  end

  // Edge detector and pending register; a new edge wins over an ack clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q_r <= 4'b0000;
      pending <= 4'b0000;
    end else begin
      req_q_r <= req;
      pending <= (pending & ~clr_s) | rise_s;
    end
  end

  // Dispatch FSM with registered handshake outputs; irq_id is latched on
  // entry to REQ so it stays stable through REQ and SERVICE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= 2'd0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            state_r   <= REQ;
            irq_valid <= 1'b1;
            irq_id    <= sel_s;
            busy      <= 1'b1;
          end else begin
            state_r   <= IDLE;
            irq_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_r   <= SERVICE;
            irq_valid <= 1'b0;
          end else begin
            irq_valid <= 1'b1;
          end
          busy <= 1'b1;
        end
        SERVICE: begin
          irq_valid <= 1'b0;
          if (eoi) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          irq_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_dispatch.sv
// Scoreboard bench for irq_dispatch: a directed sequence followed by random
// traffic, both predicted by a behavioural model of the dispatcher.
module tb_irq_dispatch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] mask = 4'b0000;
  logic       irq_ack = 1'b0;
  logic       eoi = 1'b0;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       busy;

  always #5 clk = ~clk;

  irq_dispatch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .mask      (mask),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .pending   (pending),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] pend;
    logic       busy;
    logic       valid;
    logic [1:0] id;
  } status_t;

  status_t exp_q[$];
  int      offer_q[$];

  // Behavioural model: set of pending events, phase 0=idle 1=offered 2=serving
  bit         m_pend[4];
  int         m_phase = 0;
  int         m_cur = 0;
  logic [3:0] m_req_prev = 4'b0000;

  // held stimulus for directed sequences
  logic       h_en = 1'b1;
  logic [3:0] h_req = 4'b0000;
  logic [3:0] h_mask = 4'b0000;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Predict the effect of the inputs now driven at the next rising edge.
  function automatic void model_update();
    status_t    s;
    logic [3:0] p;
    int         found;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      m_phase    = 0;
      m_cur      = 0;
      m_req_prev = 4'b0000;
    end else begin
      found = -1;
      case (m_phase)
        0: begin
          if (en) begin
            for (int i = 0; i < 4; i++)
              if (m_pend[i] && !mask[i]) found = i;
          end
          if (found >= 0) begin
            m_phase = 1;
            m_cur   = found;
            offer_q.push_back(found);
          end
        end
        1: begin
          if (irq_ack) begin
            m_pend[m_cur] = 1'b0;
            m_phase = 2;
          end
        end
        2: begin
          if (eoi) m_phase = 0;
        end
        default: m_phase = 0;
      endcase
      for (int i = 0; i < 4; i++)
        if (req[i] && !m_req_prev[i]) m_pend[i] = 1'b1;
      m_req_prev = req;
    end
    for (int i = 0; i < 4; i++) p[i] = m_pend[i];
    s.pend  = p;
    s.busy  = (m_phase != 0);
    s.valid = (m_phase == 1);
    s.id    = m_cur[1:0];
    exp_q.push_back(s);
  endfunction

  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic [3:0] mk, input logic a, input logic eo);
    @(negedge clk);
    rst_n   = r;
    en      = e;
    req     = rq;
    mask    = mk;
    irq_ack = a;
    eoi     = eo;
    model_update();
  endtask

  task automatic cyc(input logic a, input logic eo, input int n);
    for (int i = 0; i < n; i++) step(1'b1, h_en, h_req, h_mask, a, eo);
  endtask

  // Monitor: compare every cycle's status and each new offer.
  logic prev_valid = 1'b0;
  always @(posedge clk) begin
    status_t e;
    int      oid;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pending",   int'(pending),   int'(e.pend));
      chk("busy",      int'(busy),      int'(e.busy));
      chk("irq_valid", int'(irq_valid), int'(e.valid));
      chk("irq_id",    int'(irq_id),    int'(e.id));
    end
    if (irq_valid && !prev_valid) begin
      if (offer_q.size() == 0) begin
        chk("unexpected_offer", int'(irq_id), -1);
      end else begin
        oid = offer_q.pop_front();
        chk("offer_id", int'(irq_id), oid);
      end
    end
    prev_valid = irq_valid;
  end

  initial begin
    // reset with all requests high
    h_req = 4'b1111;
    step(1'b0, 1'b1, h_req, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, h_req, 4'b0000, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("rst_pending", int'(pending), 0);
    chk("rst_valid", int'(irq_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(irq_id), 0);

    // basic dispatch of source 1
    h_req = 4'b0000; cyc(1'b0, 1'b0, 2);
    h_req = 4'b0010; cyc(1'b0, 1'b0, 3);
    cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b0, 1); cyc(1'b0, 1'b1, 1); cyc(1'b0, 1'b0, 2);

    // priority and id hold while a higher source arrives
    h_req = 4'b0101; cyc(1'b0, 1'b0, 3);
    h_req = 4'b1101; cyc(1'b0, 1'b0, 2);
    cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b1, 1);

    // mask blocks dispatch but still records the event
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_mask = 4'b1000; h_req = 4'b1000; cyc(1'b0, 1'b0, 4);
    h_mask = 4'b0000; cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b1, 1);

    // enable low holds dispatch
    h_en = 1'b0; h_req = 4'b0100; cyc(1'b0, 1'b0, 5);
    h_en = 1'b1; cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b1, 1);

    // level held high gives one dispatch; toggles in SERVICE collapse
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b0010; cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 15);
    cyc(1'b0, 1'b0, 3);
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b0010; cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1);
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b0010; cyc(1'b0, 1'b0, 1);
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b0010; cyc(1'b0, 1'b0, 1);
    cyc(1'b0, 1'b1, 1); cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1); cyc(1'b0, 1'b1, 1);

    // new edge on source 2 in the same cycle as its ack
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b0100; cyc(1'b0, 1'b0, 3);
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b0100; cyc(1'b1, 1'b0, 1);
    @(posedge clk); #2;
    chk("collision_pending2", int'(pending[2]), 1);
    chk("collision_busy", int'(busy), 1);
    cyc(1'b0, 1'b1, 1); cyc(1'b0, 1'b0, 3);
    // ack and eoi together: only ack is taken
    cyc(1'b1, 1'b1, 1); cyc(1'b0, 1'b0, 2); cyc(1'b0, 1'b1, 1);

    // reset during SERVICE with two events pending
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b1010; cyc(1'b0, 1'b0, 3); cyc(1'b1, 1'b0, 1);
    h_req = 4'b0000; cyc(1'b0, 1'b0, 1);
    h_req = 4'b1010; cyc(1'b0, 1'b0, 2);
    step(1'b0, h_en, h_req, h_mask, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("midrst_pending", int'(pending), 0);
    chk("midrst_valid", int'(irq_valid), 0);
    chk("midrst_busy", int'(busy), 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] rq;
      logic [3:0] mk;
      rq = req;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(5) == 0) rq[i] = ~rq[i];
      mk = mask;
      if ($urandom_range(15) == 0) mk = 4'($urandom_range(15));
      step(($urandom_range(199) != 0), ($urandom_range(9) != 0), rq, mk,
           1'($urandom_range(1)), ($urandom_range(2) == 0));
    end

    h_req = req; h_mask = mask;
    cyc(1'b0, 1'b0, 2);
    @(posedge clk); #3;
    chk("scoreboard_drained", exp_q.size() + offer_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
